// File: rtl/mem_port_sched_if.sv
// Bundle of request, memory handshake and pipeline control signals shared
// between the processor pipeline/memory (master) and the memory port
// scheduler (slave).
`timescale 1ns/1ps

interface mem_port_sched_if;
  logic fetch_req;
  logic data_rd;
  logic data_wr;
  logic branchctrl;
  logic mem_ready;
  logic mem_en;
  logic mem_sel;
  logic mem_we;
  logic if_valid;
  logic data_done;
  logic stall;
  logic flush;
  logic err;

  modport master (
    output fetch_req, data_rd, data_wr, branchctrl, mem_ready,
    input  mem_en, mem_sel, mem_we, if_valid, data_done, stall, flush, err
  );

  modport slave (
    input  fetch_req, data_rd, data_wr, branchctrl, mem_ready,
    output mem_en, mem_sel, mem_we, if_valid, data_done, stall, flush, err
  );
endinterface

// File: rtl/mem_port_sched.sv
// Arbitrates the single shared memory port between instruction fetch and
// ldr/str data accesses. Data normally wins, but a fairness bit hands the
// port to fetch right after a data access so fetch cannot be starved.
// Also generates the pipeline freeze (stall) and the post-branch squash
// (flush), and flags a sticky error when memory never answers.
`timescale 1ns/1ps

module mem_port_sched #(
  parameter int FLUSH_CYCLES = 2,
  parameter int WAIT_MAX     = 15
) (
  input logic            clock,
  input logic            reset,
  mem_port_sched_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    DATA
  } state_t;

  state_t     state;
  logic       fair;
  logic [7:0] wait_cnt;
  logic [2:0] flush_cnt;
  logic       if_valid_q;
  logic       data_done_q;
  logic       err_q;
  logic       data_req;
  logic       flush_active;
  logic       timeout;

  assign data_req     = bus.data_rd | bus.data_wr;
  assign flush_active = (flush_cnt != 3'd0);
  assign timeout      = !bus.mem_ready && (wait_cnt == 8'(WAIT_MAX - 1));

  // Port arbitration FSM with registered done/valid pulses, fairness bit and timeout
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      fair        <= 1'b0;
      wait_cnt    <= 8'd0;
      if_valid_q  <= 1'b0;
      data_done_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      if_valid_q  <= 1'b0;
      data_done_q <= 1'b0;
      case (state)
        IDLE: begin
          wait_cnt <= 8'd0;
          if (fair && bus.fetch_req) begin
            state <= FETCH;
          end else if (data_req) begin
            state <= DATA;
          end else if (bus.fetch_req) begin
            state <= FETCH;
          end
        end
        FETCH: begin
          if (bus.mem_ready) begin
            wait_cnt   <= 8'd0;
            if_valid_q <= !flush_active;
            fair       <= 1'b0;
            if (data_req) begin
              state <= DATA;
            end else if (bus.fetch_req) begin
              state <= FETCH;
            end else begin
              state <= IDLE;
            end
          end else if (timeout) begin
            err_q    <= 1'b1;
            wait_cnt <= 8'd0;
            state    <= IDLE;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        DATA: begin
          if (bus.mem_ready) begin
            wait_cnt    <= 8'd0;
            data_done_q <= 1'b1;
            fair        <= 1'b1;
            if (bus.fetch_req) begin
              state <= FETCH;
            end else begin
              state <= IDLE;
            end
          end else if (timeout) begin
            err_q    <= 1'b1;
            wait_cnt <= 8'd0;
            state    <= IDLE;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        default: begin
          state    <= IDLE;
          wait_cnt <= 8'd0;
        end
      endcase
    end
  end

  // Squash window after a taken branch; a new branch restarts the window
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      flush_cnt <= 3'd0;
    end else if (!bus.branchctrl) begin
      flush_cnt <= 3'(FLUSH_CYCLES);
    end else if (flush_active) begin
      flush_cnt <= flush_cnt - 3'd1;
    end
  end

  // Memory strobes and pipeline freeze decoded from state and live requests
  always_comb begin
    bus.mem_en  = 1'b0;
    bus.mem_sel = 1'b0;
    bus.mem_we  = 1'b0;
    bus.stall   = 1'b0;
    case (state)
      FETCH: begin
        bus.mem_en = 1'b1;
        bus.stall  = data_req;
      end
      DATA: begin
        bus.mem_en  = 1'b1;
        bus.mem_sel = 1'b1;
        bus.mem_we  = bus.data_wr;
        bus.stall   = !bus.mem_ready;
      end
      default: begin
        bus.mem_en = 1'b0;
      end
    endcase
  end

  assign bus.if_valid  = if_valid_q;
  assign bus.data_done = data_done_q;
  assign bus.err       = err_q;
  assign bus.flush     = flush_active;

endmodule

// File: tb/tb_mem_port_sched.sv
// Directed bench for the memory port scheduler. Output vectors are packed
// as {mem_en, mem_sel, mem_we, if_valid, data_done, stall, flush, err}.
`timescale 1ns/1ps

module tb_mem_port_sched;

  logic clock;
  logic reset;
  int   checkCount;
  int   errorCount;

  mem_port_sched_if bus ();

  mem_port_sched #(
    .FLUSH_CYCLES(2),
    .WAIT_MAX    (15)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  // Free-running 10 ns clock
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  function automatic logic [7:0] outs();
    return {bus.mem_en, bus.mem_sel, bus.mem_we, bus.if_valid,
            bus.data_done, bus.stall, bus.flush, bus.err};
  endfunction

  task automatic checkOutput(input string tag, input logic [7:0] observed,
                             input logic [7:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %b, expected %b (en sel we valid done stall flush err)",
               tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic fr, input logic rd, input logic wr,
                               input logic br, input logic rdy);
    bus.fetch_req  = fr;
    bus.data_rd    = rd;
    bus.data_wr    = wr;
    bus.branchctrl = br;
    bus.mem_ready  = rdy;
    #1;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Directed scenarios in sequence
  initial begin
    checkCount = 0;
    errorCount = 0;
    reset = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    tick();
    reset = 1'b0;
    #1;
    checkOutput("reset_state", outs(), 8'b00000000);

    // Back-to-back fetches with an always-ready memory
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    checkOutput("t1_idle", outs(), 8'b00000000);
    tick();
    checkOutput("t1_grant", outs(), 8'b10000000);
    for (int i = 0; i < 4; i++) begin
      tick();
      checkOutput("t1_stream", outs(), 8'b10010000);
    end
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    tick();
    checkOutput("t1_last_valid", outs(), 8'b00010000);
    tick();
    checkOutput("t1_idle_again", outs(), 8'b00000000);

    // Simultaneous requests with fairness clear: data first, then fetch
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
    tick();
    checkOutput("t2_data_first", outs(), 8'b11000000);
    tick();
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    checkOutput("t2_fetch_second", outs(), 8'b10001000);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    tick();
    tick();
    checkOutput("t2_back_idle", outs(), 8'b00000000);

    // Lone data access sets fairness; next simultaneous request goes to fetch
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
    tick();
    tick();
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
    checkOutput("t2_done_idle", outs(), 8'b00001000);
    tick();
    checkOutput("t2_fair_fetch", outs(), 8'b10000100);
    tick();
    checkOutput("t2_data_after", outs(), 8'b11010000);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    checkOutput("t2_data_done", outs(), 8'b00001000);
    tick();

    // Write with memory holding off for three cycles
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    tick();
    for (int i = 0; i < 3; i++) begin
      checkOutput("t3_write_wait", outs(), 8'b11100100);
      tick();
    end
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    checkOutput("t3_write_ready", outs(), 8'b11100000);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    checkOutput("t3_write_done", outs(), 8'b00001000);
    tick();

    // Single taken branch during a fetch stream
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    tick();
    tick();
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("t4_pre_branch", outs(), 8'b10010000);
    tick();
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    checkOutput("t4_flush1", outs(), 8'b10010010);
    tick();
    checkOutput("t4_flush2", outs(), 8'b10000010);
    tick();
    checkOutput("t4_flush_end", outs(), 8'b10000000);
    tick();
    checkOutput("t4_valid_back", outs(), 8'b10010000);

    // Two taken branches on consecutive cycles stretch the window to three
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    checkOutput("t4b_flush1", outs(), 8'b10010010);
    tick();
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    checkOutput("t4b_flush2", outs(), 8'b10000010);
    tick();
    checkOutput("t4b_flush3", outs(), 8'b10000010);
    tick();
    checkOutput("t4b_flush_off", outs(), 8'b10000000);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    tick();
    tick();

    // Memory never answers a read: timeout after fifteen waiting cycles
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    tick();
    for (int i = 0; i < 15; i++) begin
      checkOutput("t5_waiting", outs(), 8'b11000100);
      tick();
    end
    checkOutput("t5_timeout", outs(), 8'b00000001);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    checkOutput("t5_sticky", outs(), 8'b00000001);
    tick();
    tick();
    checkOutput("t5_sticky_later", outs(), 8'b00000001);

    // Asynchronous reset in the middle of a data access
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    tick();
    checkOutput("t6_in_data", outs(), 8'b11000101);
    #2;
    reset = 1'b1;
    #1;
    checkOutput("t6_async_reset", outs(), 8'b00000000);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
    tick();
    reset = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    checkOutput("t6_released", outs(), 8'b00000000);
    tick();
    checkOutput("t6_no_done", outs(), 8'b00000000);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
